// File: rtl/trans_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : trans_out_requant
// Brief    : Round/saturate 22.18 FIR output to 12.10, decimate, and buffer
//            in a small valid/ready FIFO with saturation/overflow statistics.
// Revision : 1.0  initial release
// ============================================================================
module trans_out_requant #(
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [21:0] trans_out,
    output logic [11:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  sat_cnt,
    output logic        overflow,
    input  logic        clr_stat
);

    localparam int c_PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = c_AW + 1;
    localparam logic [c_PH_W-1:0]  c_PH_MAX = c_PH_W'(DECIM - 1);
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);

    // Quantizer: adding half an output LSB before the floor shift rounds half-up
    logic signed [22:0] w_s;
    logic signed [14:0] w_q;
    logic               w_sat_hi;
    logic               w_sat_lo;
    logic [11:0]        w_qdata;

    assign w_s      = {trans_out[21], trans_out} + 23'sd128;
    assign w_q      = 15'(w_s >>> 8);
    assign w_sat_hi = (w_q > 15'sd2047);
    assign w_sat_lo = (w_q < -15'sd2048);
    assign w_qdata  = w_sat_hi ? 12'h7FF : (w_sat_lo ? 12'h800 : w_q[11:0]);

    logic [c_PH_W-1:0] r_ph;
    logic              w_keep;
    logic              r_q_vld;
    logic              r_q_sat;
    logic [11:0]       r_q_data;

    assign w_keep = in_valid && (r_ph == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ph     <= '0;
            r_q_vld  <= 1'b0;
            r_q_sat  <= 1'b0;
            r_q_data <= '0;
        end else begin
            if (in_valid)
                r_ph <= (r_ph == c_PH_MAX) ? '0 : r_ph + 1'b1;
            r_q_vld <= w_keep;
            if (w_keep) begin
                r_q_data <= w_qdata;
                r_q_sat  <= w_sat_hi || w_sat_lo;
            end
        end
    end

    // FIFO: a full FIFO still accepts a push when the head leaves the same cycle
    logic [11:0]        r_mem [DEPTH];
    logic [c_AW-1:0]    r_wptr;
    logic [c_AW-1:0]    r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_full    = (r_count == c_FULL);
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = r_q_vld && (!w_full || w_pop);
    assign w_drop    = r_q_vld && w_full && !w_pop;
    assign out_data  = out_valid ? r_mem[r_rptr] : 12'd0;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= r_q_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Saturation is counted on the push attempt, even if the entry is dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_cnt  <= '0;
            overflow <= 1'b0;
        end else if (clr_stat) begin
            sat_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (r_q_vld && r_q_sat && (sat_cnt != 8'hFF))
                sat_cnt <= sat_cnt + 1'b1;
            if (w_drop)
                overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trans_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_trans_out_requant
// Brief    : Directed self-checking bench; DUT a is DECIM=1, DUT b is DECIM=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_trans_out_requant;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        a_in_valid = 1'b0, b_in_valid = 1'b0;
    logic [21:0] a_trans_out = '0, b_trans_out = '0;
    logic [11:0] a_out_data, b_out_data;
    logic        a_out_valid, b_out_valid;
    logic        a_out_ready = 1'b0, b_out_ready = 1'b0;
    logic [7:0]  a_sat_cnt, b_sat_cnt;
    logic        a_overflow, b_overflow;
    logic        a_clr_stat = 1'b0, b_clr_stat = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] b_seen [$];

    always #5 clk = ~clk;

    trans_out_requant #(.DECIM(1), .DEPTH(4)) u_a (
        .clk(clk), .rstn(rstn), .in_valid(a_in_valid), .trans_out(a_trans_out),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sat_cnt(a_sat_cnt), .overflow(a_overflow), .clr_stat(a_clr_stat)
    );

    trans_out_requant #(.DECIM(4), .DEPTH(4)) u_b (
        .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .trans_out(b_trans_out),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sat_cnt(b_sat_cnt), .overflow(b_overflow), .clr_stat(b_clr_stat)
    );

    always @(negedge clk)
        if (b_out_valid && b_out_ready)
            b_seen.push_back(b_out_data);

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_a(input logic [21:0] v);
        a_in_valid = 1'b1;
        a_trans_out = v;
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [21:0] v);
        b_in_valid = 1'b1;
        b_trans_out = v;
        step();
        b_in_valid = 1'b0;
    endtask

    task automatic send_get_a(input string name, input logic [21:0] v, input logic [11:0] exp);
        drive_a(v);
        for (int i = 0; i < 6 && !a_out_valid; i++) step();
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_data !== exp) begin
            n_fail++;
            $display("FAIL %s: valid=%b data=%h, required valid=1 data=%h", name, a_out_valid, a_out_data, exp);
        end
        step();
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b0 || a_out_data !== 12'd0 || a_sat_cnt !== 8'd0 || a_overflow !== 1'b0 ||
            b_out_valid !== 1'b0 || b_out_data !== 12'd0 || b_sat_cnt !== 8'd0 || b_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: a v=%b d=%h s=%0d o=%b b v=%b d=%h s=%0d o=%b, required all 0",
                     a_out_valid, a_out_data, a_sat_cnt, a_overflow, b_out_valid, b_out_data, b_sat_cnt, b_overflow);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_rounding;
        a_out_ready = 1'b1;
        send_get_a("round_0x80", 22'h000080, 12'h001);
        send_get_a("round_0x7f", 22'h00007F, 12'h000);
        send_get_a("round_m128", 22'h3FFF80, 12'h000);
        send_get_a("round_m129", 22'h3FFF7F, 12'hFFF);
        n_tests++;
        if (a_sat_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL round_satcnt: got %0d, required 0", a_sat_cnt);
        end
    endtask

    task automatic test_saturation;
        send_get_a("sat_pos", 22'h1FFFFF, 12'h7FF);
        send_get_a("sat_neg", 22'h200000, 12'h800);
        n_tests++;
        if (a_sat_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL sat_cnt: got %0d, required 2", a_sat_cnt);
        end
        a_clr_stat = 1'b1;
        step();
        a_clr_stat = 1'b0;
        n_tests++;
        if (a_sat_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_clr: got %0d, required 0", a_sat_cnt);
        end
    endtask

    task automatic test_decimation;
        b_out_ready = 1'b1;
        b_seen.delete();
        for (int n = 0; n < 8; n++) begin
            if (n == 4) step();
            drive_b(22'(n * 256));
        end
        for (int i = 0; i < 6; i++) step();
        n_tests++;
        if (b_seen.size() != 2) begin
            n_fail++;
            $display("FAIL decim_count: got %0d outputs, required 2", b_seen.size());
        end else begin
            if (b_seen[0] !== 12'd0 || b_seen[1] !== 12'd4) begin
                n_fail++;
                $display("FAIL decim_values: got %h,%h, required 000,004", b_seen[0], b_seen[1]);
            end
        end
    endtask

    task automatic test_backpressure;
        a_out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) drive_a(22'(v * 256));
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_data !== 12'd1 || a_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: v=%b d=%h ovf=%b, required v=1 d=001 ovf=0", a_out_valid, a_out_data, a_overflow);
        end
        step();
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_data !== 12'd1 || a_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_overflow: v=%b d=%h ovf=%b, required v=1 d=001 ovf=1", a_out_valid, a_out_data, a_overflow);
        end
        a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_data !== 12'(i)) begin
                n_fail++;
                $display("FAIL bp_pop%0d: v=%b d=%h, required v=1 d=%h", i, a_out_valid, a_out_data, 12'(i));
            end
            step();
        end
        n_tests++;
        if (a_out_valid !== 1'b0 || a_out_data !== 12'd0) begin
            n_fail++;
            $display("FAIL bp_empty: v=%b d=%h, required v=0 d=000", a_out_valid, a_out_data);
        end
        a_clr_stat = 1'b1;
        step();
        a_clr_stat = 1'b0;
    endtask

    task automatic test_full_push_pop;
        a_out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) drive_a(22'(v * 256));
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b1 || a_out_data !== 12'd2 || a_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_head: v=%b d=%h ovf=%b, required v=1 d=002 ovf=0", a_out_valid, a_out_data, a_overflow);
        end
        a_out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            n_tests++;
            if (a_out_valid !== 1'b1 || a_out_data !== 12'(i)) begin
                n_fail++;
                $display("FAIL fpp_pop%0d: v=%b d=%h, required v=1 d=%h", i, a_out_valid, a_out_data, 12'(i));
            end
            step();
        end
        n_tests++;
        if (a_out_valid !== 1'b0 || a_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_end: v=%b ovf=%b, required v=0 ovf=0", a_out_valid, a_overflow);
        end
    endtask

    task automatic test_reset_mid;
        b_out_ready = 1'b0;
        for (int n = 0; n < 10; n++)
            drive_b((n == 0 || n == 4) ? 22'h1FFFFF : ((n == 8) ? 22'h000300 : 22'h0));
        n_tests++;
        if (b_out_valid !== 1'b1 || b_out_data !== 12'h7FF || b_sat_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL rst_pre: v=%b d=%h s=%0d, required v=1 d=7ff s=2", b_out_valid, b_out_data, b_sat_cnt);
        end
        #2 rstn = 1'b0;
        #1;
        n_tests++;
        if (b_out_valid !== 1'b0 || b_out_data !== 12'd0 || b_sat_cnt !== 8'd0 || b_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: v=%b d=%h s=%0d o=%b, required all 0", b_out_valid, b_out_data, b_sat_cnt, b_overflow);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
        b_out_ready = 1'b1;
        drive_b(22'h000500);
        for (int i = 0; i < 6 && !b_out_valid; i++) step();
        n_tests++;
        if (b_out_valid !== 1'b1 || b_out_data !== 12'd5) begin
            n_fail++;
            $display("FAIL rst_keep: v=%b d=%h, required v=1 d=005", b_out_valid, b_out_data);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_decimation();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trans_out_requant.md
# trans_out_requant

Output stage placed directly downstream of the 5-tap transposed FIR, consuming its 22-bit (22.18) `trans_out` stream. Each sample is rounded and saturated to 12-bit (12.10), decimated by a fixed factor, and buffered in a small FIFO. The FIFO drains through a valid/ready handshake to the next block. Saturation events and FIFO overflow are reported on status outputs.

## Interface
- `DECIM`, default 4: decimation factor, legal range 1..16.
- `DEPTH`, default 4: FIFO depth; must be a power of 2, range 2..16.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  `trans_out` holds a new filter sample this cycle.
- `trans_out`  in  22  signed filter output, format 22.18.
- `out_data`  out  12  signed sample, format 12.10; FIFO head.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `sat_cnt`  out  8  count of saturated kept samples; saturates at 255.
- `overflow`  out  1  sticky flag: a kept sample was dropped.
- `clr_stat`  in  1  synchronous clear of `sat_cnt` and `overflow`.

## Operation
- **Quantize.**
  - Form `s = sext23(trans_out) + 128`, then `q = s >>> 8` (arithmetic shift, 15-bit result). This is round-half-up at the 2^-10 LSB.
  - If `q > 2047`, output 2047. If `q < -2048`, output -2048. Either case marks the sample saturated.
- **Decimate.**
  - Phase counter `ph` runs 0..DECIM-1 and advances only on `in_valid`, wrapping DECIM-1 -> 0.
  - A sample is kept when `in_valid` is high and `ph == 0`. The first valid sample after reset is kept.
  - With `DECIM = 1`, every valid sample is kept.
- **Pipeline register.**
  - A kept sample is stored, quantized, into `q_reg` with its `q_vld` and `q_sat` bits at the same edge.
  - On the next edge, a set `q_vld` causes a push into the FIFO.
- **FIFO.**
  - Circular buffer with read/write pointers plus a count of 0..DEPTH.
  - Pop when `out_valid && out_ready`.
  - Full and push, no pop: the sample is dropped and `overflow` is set.
  - Full and push with pop in the same cycle: both happen, no drop.
  - Empty and push with `out_ready`: no pop that cycle. There is no bypass.
- **Output.**
  - `out_valid = (count != 0)`.
  - `out_data` = head entry when `out_valid` is high, otherwise 12'd0.
  - `out_data` must stay stable while `out_valid && !out_ready`.
- **Statistics.**
  - `sat_cnt` increments by 1 when a saturated `q_reg` entry is pushed, whether or not the push is dropped. It holds at 255.
  - `clr_stat` wins over a same-cycle increment or overflow set; the result is 0.

## Timing
- **Reset (async, `rstn` = 0):**
  - `ph` = 0, `q_vld` = 0, FIFO empty, pointers = 0.
  - `out_valid` = 0, `out_data` = 0, `sat_cnt` = 0, `overflow` = 0.
  - Outputs change immediately when reset asserts, without waiting for `clk`.
  - Reset mid-stream discards all buffered data.
- **Latency:** a kept sample sampled at edge k gives `out_valid` = 1 after edge k+1, when the FIFO was empty. This is 2 edges from input to output.
- **Throughput:** with `DECIM = 1` and `out_ready` held high, the block sustains one sample per clock.
- **Timing of `overflow` and `sat_cnt` updates:** both change at the edge that performs, or attempts, the push.
- **Unkept samples:** `in_valid` = 0, or phase not 0, leaves `q_vld` = 0 on the next edge.

## Test plan
- **Rounding** (DECIM = 1, `out_ready` = 1).
  - Stimulus: `trans_out` sequence 0x000080, 0x00007F, 0x3FFF80 (-128), 0x3FFF7F (-129).
  - Required: `out_data` = 1, 0, 0, -1; `sat_cnt` = 0.
- **Saturation.**
  - Stimulus: 0x1FFFFF, then 0x200000.
  - Required: `out_data` = 2047, then -2048; `sat_cnt` = 2.
  - Then pulse `clr_stat`; required: `sat_cnt` = 0.
- **Decimation** (DECIM = 4).
  - Stimulus: 8 consecutive valid samples of n·256, n = 0..7, with one idle cycle between samples 3 and 4.
  - Required: outputs exactly 0 then 4; the idle cycle must not advance `ph`.
- **Backpressure and overflow** (DEPTH = 4, DECIM = 1).
  - Stimulus: `out_ready` = 0, push values 1..5.
  - Required: `out_valid` = 1 and `out_data` = 1 held stable; `overflow` = 1 after the 5th push.
  - Then `out_ready` = 1; required: pops 1, 2, 3, 4, then `out_valid` = 0.
- **Full with simultaneous push and pop.**
  - Stimulus: FIFO full with 1..4; push 5 with `out_ready` = 1.
  - Required: 1 popped, FIFO holds 2..5, `overflow` stays 0.
- **Reset mid-operation.**
  - Stimulus: 3 entries buffered, `sat_cnt` = 2, `ph` = 2; assert `rstn` = 0 between clock edges.
  - Required: `out_valid`, `out_data`, `sat_cnt` and `overflow` go to 0 immediately.
  - After release, the next valid sample is kept.
